vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, framebuffer word-address width (320x240 image).
REQ-002 Parameter DATA_W, default 8, pixel word width.
REQ-003 Parameter STARVE_LIMIT, default 800, coprocessor wait cycles before starvation flag.
REQ-004 clk  in  1  single pixel-domain clock (25 MHz); all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 vga_req  in  1  scanout fetch request, one pulse per pixel word.
REQ-007 vga_addr  in  ADDR_W  scanout fetch address, valid with vga_req.
REQ-008 vga_valid  out  1  one-cycle pulse, vga_data holds fetched word.
REQ-009 vga_data  out  DATA_W  fetched scanout word.
REQ-010 cp_req  in  1  coprocessor access request, level, held until cp_ack.
REQ-011 cp_we  in  1  1 = write, 0 = read; stable while cp_req high.
REQ-012 cp_addr  in  ADDR_W  coprocessor address; stable while cp_req high.
REQ-013 cp_wdata  in  DATA_W  coprocessor write data; stable while cp_req high.
REQ-014 cp_ack  out  1  one-cycle completion pulse.
REQ-015 cp_rdata  out  DATA_W  read data, valid with cp_ack on reads.
REQ-016 mem_addr  out  ADDR_W  registered single-port RAM address.
REQ-017 mem_we  out  1  registered RAM write enable.
REQ-018 mem_wdata  out  DATA_W  registered RAM write data.
REQ-019 mem_rdata  in  DATA_W  RAM read data, synchronous, valid cycle after address cycle.
REQ-020 cp_starved  out  1  sticky flag: coprocessor waited >= STARVE_LIMIT cycles.

Function
REQ-021 One RAM issue slot per cycle; issue decided from inputs sampled at rising edge of cycle N, driven on mem_* during N+1.
REQ-022 Priority fixed: vga_req high in N wins the slot unconditionally; cp_req granted only in cycles with vga_req low.
REQ-023 Grant FSM states: IDLE (no issue), VGA (scanout read issued), CP_WR, CP_RD, CP_WAIT (coprocessor read in flight); one issue per cycle.
REQ-024 VGA read latency fixed: vga_valid high exactly in cycle N+3 for vga_req in N; back-to-back vga_req every cycle yields vga_valid every cycle, in order.
REQ-025 Read tags (vga / cp / none) travel through a 2-stage pipeline alongside RAM latency; returned data routed by tag only.
REQ-026 CP write granted in N: mem_we=1 in N+1 with cp_addr/cp_wdata; cp_ack pulse in N+1.
REQ-027 CP read granted in N: mem_we=0 in N+1; cp_ack with cp_rdata in N+3; FSM in CP_WAIT, no further cp grant until cp_ack cycle done.
REQ-028 cp_req sampled in the cp_ack cycle is ignored; earliest next cp grant is cycle after cp_ack.
REQ-029 mem_we=0 in every cycle not carrying a granted CP write; mem_addr/mem_wdata hold last values when idle.
REQ-030 Wait counter counts cycles with cp_req high and no grant, clears on grant, saturates at STARVE_LIMIT; cp_starved set when counter reaches STARVE_LIMIT, cleared only by reset.
REQ-031 vga_data/cp_rdata hold last delivered value between pulses.
REQ-032 Simultaneous vga_valid and cp_ack in one cycle permitted (different tags); both outputs update.

Reset
REQ-033 rst_n low forces immediately: vga_valid=0, cp_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_data=0, cp_rdata=0, cp_starved=0, wait counter=0, tag pipeline empty, FSM IDLE.
REQ-034 Reads in flight at reset are discarded: no vga_valid or cp_ack produced for them after rst_n rises.
REQ-035 First grant possible in first cycle rst_n sampled high.

Verification
REQ-036 vga_req at N, addr 0x00010, RAM holds 0x5A -> mem_addr=0x00010 at N+1, vga_valid=1, vga_data=0x5A at N+3.
REQ-037 cp_req write addr 0x00020 data 0xC3, vga_req low -> mem_we=1 at N+1, cp_ack at N+1; later VGA fetch of 0x00020 returns 0xC3.
REQ-038 vga_req held high 10 cycles, cp_req read pending -> 10 vga_valid pulses in order, cp grant first cycle vga_req low, cp_ack 3 cycles later.
REQ-039 cp_req held, vga_req high for STARVE_LIMIT cycles -> cp_starved=1 at limit, stays 1 after grant until reset.
REQ-040 rst_n low one cycle after vga_req and cp read grant -> no vga_valid, no cp_ack afterwards; all outputs zero during reset.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one synchronous single-port RAM between VGA
// scanout fetches (absolute priority) and a coprocessor read/write port.
// Read data returns through a tagged two-stage pipeline; a wait counter
// flags coprocessor starvation.
module vga_fb_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_valid,
   output logic [DATA_W-1:0] vga_data,
   input  logic              cp_req,
   input  logic              cp_we,
   input  logic [ADDR_W-1:0] cp_addr,
   input  logic [DATA_W-1:0] cp_wdata,
   output logic              cp_ack,
   output logic [DATA_W-1:0] cp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cp_starved
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   // State names what the arbiter issued (or is waiting on) this cycle.
   typedef enum logic [2:0] {IDLE, VGA, CP_WR, CP_RD, CP_WAIT} state_t;
   // Owner of the read data travelling alongside the RAM latency.
   typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CP} tag_t;

   state_t             r_state;
   state_t             w_state_next;
   tag_t               w_issue_tag;
   tag_t               r_tag_s1;
   tag_t               r_tag_s2;

   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_mem_we;
   logic [DATA_W-1:0]  r_mem_wdata;

   logic               r_vga_valid;
   logic [DATA_W-1:0]  r_vga_data;
   logic               r_cp_ack;
   logic [DATA_W-1:0]  r_cp_rdata;

   logic [CNT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]   w_wait_cnt_next;
   logic               r_cp_starved;

   logic               w_cp_rd_inflight;
   logic               w_cp_block;
   logic               w_cp_grant;

   // A coprocessor read is outstanding from its issue cycle until its ack;
   // the ack cycle itself (read or write) also refuses a new grant because
   // the requester still holds cp_req while it sees the ack.
   assign w_cp_rd_inflight = (r_state == CP_RD) || (r_tag_s2 == TAG_CP);
   assign w_cp_block       = w_cp_rd_inflight || r_cp_ack;
   assign w_cp_grant       = cp_req && !vga_req && !w_cp_block;

   // Grant decision: scanout wins outright, coprocessor takes idle slots.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_state_next = IDLE;
      w_issue_tag  = TAG_NONE;
      if (vga_req) begin
         w_state_next = VGA;
         w_issue_tag  = TAG_VGA;
      end else if (w_cp_grant) begin
         w_state_next = cp_we ? CP_WR : CP_RD;
         w_issue_tag  = cp_we ? TAG_NONE : TAG_CP;
      end else if (w_cp_rd_inflight) begin
         w_state_next = CP_WAIT;
      end
   end

   // State register and read-tag pipeline; reset empties both so reads in
   // flight are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_tag_s1 <= TAG_NONE;
         r_tag_s2 <= TAG_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         r_state  <= w_state_next;
         r_tag_s1 <= w_issue_tag;
         r_tag_s2 <= r_tag_s1;
      end
   end

   // Registered RAM command; address and write data hold when no issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= 1'b0;
         if (vga_req) begin
            r_mem_addr <= vga_addr;
         end else if (w_cp_grant) begin
            r_mem_addr <= cp_addr;
            r_mem_we   <= cp_we;
            if (cp_we) begin
               r_mem_wdata <= cp_wdata;
            end
         end
      end
   end

   // Route returning RAM data by tag; data outputs hold between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vga_valid <= 1'b0;
         r_vga_data  <= '0;
         r_cp_ack    <= 1'b0;
         r_cp_rdata  <= '0;
      end else begin
         r_vga_valid <= (r_tag_s2 == TAG_VGA);
         r_cp_ack    <= (w_cp_grant && cp_we) || (r_tag_s2 == TAG_CP);
         if (r_tag_s2 == TAG_VGA) begin
            r_vga_data <= mem_rdata;
         end
         if (r_tag_s2 == TAG_CP) begin
            r_cp_rdata <= mem_rdata;
         end
      end
   end

   // Wait counter: runs while a request is refused for a grant, clears on
   // grant or when the request drops, saturates at the limit.
   always_comb begin
      w_wait_cnt_next = r_wait_cnt;
      if (!cp_req || w_cp_grant) begin
         w_wait_cnt_next = '0;
      end else if (!w_cp_block && (r_wait_cnt < CNT_W'(STARVE_LIMIT))) begin
         w_wait_cnt_next = r_wait_cnt + 1'b1;
      end
   end

   // Counter register and sticky starvation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt   <= '0;
         r_cp_starved <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_cnt_next;
         if (w_wait_cnt_next == CNT_W'(STARVE_LIMIT)) begin
            r_cp_starved <= 1'b1;
         end
      end
   end

   assign vga_valid  = r_vga_valid;
   assign vga_data   = r_vga_data;
   assign cp_ack     = r_cp_ack;
   assign cp_rdata   = r_cp_rdata;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;
   assign cp_starved = r_cp_starved;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous RAM.
module tb_vga_fb_arbiter;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_valid;
   logic [DATA_W-1:0] vga_data;
   logic              cp_req;
   logic              cp_we;
   logic [ADDR_W-1:0] cp_addr;
   logic [DATA_W-1:0] cp_wdata;
   logic              cp_ack;
   logic [DATA_W-1:0] cp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              cp_starved;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_pass   = 0;

   vga_fb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_valid  (vga_valid),
      .vga_data   (vga_data),
      .cp_req     (cp_req),
      .cp_we      (cp_we),
      .cp_addr    (cp_addr),
      .cp_wdata   (cp_wdata),
      .cp_ack     (cp_ack),
      .cp_rdata   (cp_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cp_starved (cp_starved)
   );

   // 25 MHz pixel clock
   always #20 clk = ~clk;

   // Synchronous single-port RAM: data for the address of cycle N appears in N+1.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vga_valid"},  32'(vga_valid),  32'h0);
      check({tag, "_cp_ack"},     32'(cp_ack),     32'h0);
      check({tag, "_mem_we"},     32'(mem_we),     32'h0);
      check({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
      check({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
      check({tag, "_vga_data"},   32'(vga_data),   32'h0);
      check({tag, "_cp_rdata"},   32'(cp_rdata),   32'h0);
      check({tag, "_cp_starved"}, 32'(cp_starved), 32'h0);
   endtask

   initial begin
      int n_valid;
      int first_valid;
      int ack_cyc;
      int ack1_cyc;
      int ack2_cyc;
      logic [DATA_W-1:0] ack1_data;
      logic [DATA_W-1:0] ack2_data;
      int n_seen;

      // RAM preload: word a holds low byte of 7a+3, except 0x10 holds 0x5A.
      for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'(a * 7 + 3);
      ram[17'h10] = 8'h5A;
      mem_rdata = '0;

      rst_n = 1'b0;
      vga_req = 1'b0; vga_addr = '0;
      cp_req = 1'b0; cp_we = 1'b0; cp_addr = '0; cp_wdata = '0;
      repeat (2) tick();
      check_all_zero("reset");

      // Scanout fetch issued in the first cycle reset is sampled high.
      rst_n = 1'b1;
      vga_req = 1'b1; vga_addr = 17'h10;
      tick();                                           // N+1
      check("vga_mem_addr", 32'(mem_addr), 32'h10);
      check("vga_mem_we",   32'(mem_we),   32'h0);
      vga_req = 1'b0;
      tick();                                           // N+2
      check("vga_n2_valid", 32'(vga_valid), 32'h0);
      tick();                                           // N+3
      check("vga_n3_valid", 32'(vga_valid), 32'h1);
      check("vga_n3_data",  32'(vga_data),  32'h5A);
      tick();
      check("vga_n4_valid", 32'(vga_valid), 32'h0);
      check("vga_hold",     32'(vga_data),  32'h5A);

      // Coprocessor write, acknowledged in the slot it occupies.
      cp_req = 1'b1; cp_we = 1'b1; cp_addr = 17'h20; cp_wdata = 8'hC3;
      tick();
      check("wr_mem_we",    32'(mem_we),    32'h1);
      check("wr_mem_addr",  32'(mem_addr),  32'h20);
      check("wr_mem_wdata", 32'(mem_wdata), 32'hC3);
      check("wr_ack",       32'(cp_ack),    32'h1);
      cp_req = 1'b0; cp_we = 1'b0;
      tick();
      check("wr_after_we",   32'(mem_we),    32'h0);
      check("wr_after_ack",  32'(cp_ack),    32'h0);
      check("idle_addr_hold",  32'(mem_addr),  32'h20);
      check("idle_wdata_hold", 32'(mem_wdata), 32'hC3);
      vga_req = 1'b1; vga_addr = 17'h20;
      tick();
      vga_req = 1'b0;
      tick();
      tick();
      check("wr_readback_valid", 32'(vga_valid), 32'h1);
      check("wr_readback_data",  32'(vga_data),  32'hC3);
      tick();

      // Ten back-to-back fetches with a coprocessor read pending (0x30 -> 0x53).
      cp_req = 1'b1; cp_we = 1'b0; cp_addr = 17'h30;
      n_valid = 0; first_valid = -1; ack_cyc = -1;
      for (int i = 0; i < 16; i++) begin
         vga_req  = (i < 10);
         vga_addr = 17'h100 + 17'(i);
         tick();
         if (vga_valid) begin
            if (n_valid == 0) first_valid = i + 1;
            check("burst_data", 32'(vga_data), 32'(8'(7 * n_valid + 3)));
            n_valid++;
         end
         if (cp_ack) begin
            ack_cyc = i + 1;
            check("burst_cp_rdata", 32'(cp_rdata), 32'h53);
            cp_req = 1'b0;
         end
      end
      check("burst_count",  32'(n_valid),     32'd10);
      check("burst_first",  32'(first_valid), 32'd3);
      check("burst_cp_ack", 32'(ack_cyc),     32'd13);

      // Held cp_req: the ack cycle is ignored, next grant the cycle after.
      cp_req = 1'b1; cp_we = 1'b0; cp_addr = 17'h31;
      ack1_cyc = -1; ack2_cyc = -1; ack1_data = '0; ack2_data = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i + 1 == 5) check("b2b_second_addr", 32'(mem_addr), 32'h32);
         if (cp_ack) begin
            if (ack1_cyc < 0) begin
               ack1_cyc = i + 1; ack1_data = cp_rdata; cp_addr = 17'h32;
            end else begin
               ack2_cyc = i + 1; ack2_data = cp_rdata; cp_req = 1'b0;
            end
         end
      end
      check("b2b_ack1_cyc",  32'(ack1_cyc),  32'd3);
      check("b2b_ack1_data", 32'(ack1_data), 32'h5A);
      check("b2b_ack2_cyc",  32'(ack2_cyc),  32'd7);
      check("b2b_ack2_data", 32'(ack2_data), 32'h61);

      // vga_valid and a write ack landing in the same cycle.
      vga_req = 1'b1; vga_addr = 17'h10;
      tick();
      vga_req = 1'b0;
      tick();
      cp_req = 1'b1; cp_we = 1'b1; cp_addr = 17'h50; cp_wdata = 8'h99;
      tick();
      check("both_vga_valid", 32'(vga_valid), 32'h1);
      check("both_vga_data",  32'(vga_data),  32'h5A);
      check("both_cp_ack",    32'(cp_ack),    32'h1);
      check("both_rdata_hold", 32'(cp_rdata), 32'h61);
      cp_req = 1'b0; cp_we = 1'b0;
      repeat (3) tick();

      // Starvation: write held behind 800 consecutive scanout cycles.
      cp_req = 1'b1; cp_we = 1'b1; cp_addr = 17'h40; cp_wdata = 8'h77;
      vga_req = 1'b1; vga_addr = 17'h10;
      repeat (799) tick();
      check("starve_below", 32'(cp_starved), 32'h0);
      tick();
      check("starve_at",    32'(cp_starved), 32'h1);
      vga_req = 1'b0;
      tick();
      check("starve_grant_ack", 32'(cp_ack),     32'h1);
      check("starve_after_ack", 32'(cp_starved), 32'h1);
      cp_req = 1'b0; cp_we = 1'b0;
      repeat (5) tick();
      check("starve_sticky", 32'(cp_starved), 32'h1);

      // Reset with a scanout read and a coprocessor read in flight.
      vga_req = 1'b1; vga_addr = 17'h10;
      tick();
      vga_req = 1'b0;
      cp_req = 1'b1; cp_we = 1'b0; cp_addr = 17'h30;
      tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("inreset");
      cp_req = 1'b0;
      tick();
      rst_n = 1'b1;
      n_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (vga_valid || cp_ack) n_seen++;
      end
      check("flushed_reads", 32'(n_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
